// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file geometry and data types
package regfile_pkg;
    localparam int RF_AW    = 3;
    localparam int RF_DW    = 8;
    localparam int RF_DEPTH = 8;
    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;
endpackage

// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if: requester-side request/grant/response bus
interface regfile_port_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = regfile_pkg::RF_AW,
    parameter int DW   = regfile_pkg::RF_DW
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter; one-hot grant, pointer moves past the winner
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt;
    logic [PW:0]   idx;
    // walk from the farthest candidate back to the pointer so the closest one wins
    always_comb begin
        gnt = '0;
        nxt = ptr;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (PW + 1)'(i);
            idx = idx >= (PW + 1)'(N) ? idx - (PW + 1)'(N) : idx;
            if (req[idx[PW-1:0]]) begin
                gnt = '0;
                gnt[idx[PW-1:0]] = 1'b1;
                nxt = idx[PW-1:0] == PW'(N - 1) ? '0 : idx[PW-1:0] + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) ptr <= '0;
        else ptr <= nxt;
endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares a 1R1W register file between NREQ requesters,
// independent round-robin per port, 2-cycle reads with write-to-read forwarding
module regfile_port_arbiter import regfile_pkg::*; #(
    parameter int NREQ = 3,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_port_arbiter_if.slave bus,
    output logic [AW-1:0]        rf_rdreg,
    output logic [AW-1:0]        rf_wtreg,
    output logic [DW-1:0]        rf_wtdt,
    output logic                 rf_rgw,
    input  logic [DW-1:0]        rf_rdt
);
    logic [NREQ-1:0] rd_req, wr_req, rd_gnt, wr_gnt, pend;
    logic [AW-1:0]   rd_addr, wr_addr;
    logic [DW-1:0]   wr_data;

    // no grants while reset is held
    assign rd_req = {NREQ{rst}} & bus.req_valid & ~bus.req_we;
    assign wr_req = {NREQ{rst}} & bus.req_valid & bus.req_we;
    assign bus.req_ready = rd_gnt | wr_gnt;

    rr_arbiter #(.N(NREQ)) u_rd (.clk(clk), .rst(rst), .req(rd_req), .gnt(rd_gnt));
    rr_arbiter #(.N(NREQ)) u_wr (.clk(clk), .rst(rst), .req(wr_req), .gnt(wr_gnt));

    always_comb begin
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            rd_addr |= rd_gnt[k] ? bus.req_addr[k*AW +: AW] : '0;
            wr_addr |= wr_gnt[k] ? bus.req_addr[k*AW +: AW] : '0;
            wr_data |= wr_gnt[k] ? bus.req_wdata[k*DW +: DW] : '0;
        end
    end

    // pend holds the one-hot id of the read whose address is on rf_rdreg
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_rdreg      <= '0;
            rf_wtreg      <= '0;
            rf_wtdt       <= '0;
            rf_rgw        <= 1'b0;
            pend          <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
        end else begin
            rf_rgw        <= |wr_gnt;
            pend          <= rd_gnt;
            bus.rsp_valid <= pend;
            if (|wr_gnt) begin
                rf_wtreg <= wr_addr;
                rf_wtdt  <= wr_data;
            end
            if (|rd_gnt) rf_rdreg <= rd_addr;
            if (|pend) bus.rsp_data <= rf_rgw && rf_wtreg == rf_rdreg ? rf_wtdt : rf_rdt;
        end
    end
endmodule
